vector_check_engine: RTL

- Parametrised, synthesisable self-checking stimulus/response engine for unit-level verification of datapath blocks (adder, ALU, extend, regfile read paths and similar).
- Holds a vector RAM of {stimulus, expected, mask} entries. It drives each stimulus to the DUT, samples the DUT response a fixed LAT cycles later and performs a masked compare.
- Accumulates pass/fail counts and records the first failing index.
- Extends file-driven unit benches with configurable width, depth, DUT latency and stop-on-fail, so the same checks run in hardware.

---
 rtl/vector_check_engine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vector_check_engine.sv
// Vector-driven stimulus/response checker: replays {stim, exp, mask} entries
// into a DUT, compares the masked response LAT cycles later and tallies the results.
module vector_check_engine #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 64,
  parameter int LAT          = 1,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vec_we,
  input  logic [AW-1:0]    vec_waddr,
  input  logic [WIDTH-1:0] vec_stim,
  input  logic [WIDTH-1:0] vec_exp,
  input  logic [WIDTH-1:0] vec_mask,
  input  logic [AW:0]      num_vecs,
  input  logic             start,
  output logic [WIDTH-1:0] dut_stim,
  output logic             dut_valid,
  input  logic [WIDTH-1:0] dut_resp,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [AW:0]      pass_count,
  output logic [AW:0]      fail_count,
  output logic [AW-1:0]    first_fail_idx,
  output logic             first_fail_valid
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW-1:0] IDX_ZERO  = AW'(1'b0);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1'b1);
  localparam logic [3:0]    WAIT_LAST = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_CMP, ST_DONE} state_t;

  logic [WIDTH-1:0] stim_mem_r [DEPTH];
  logic [WIDTH-1:0] exp_mem_r  [DEPTH];
  logic [WIDTH-1:0] mask_mem_r [DEPTH];

  state_t        state_r, state_next_s;
  logic [AW-1:0] idx_r, idx_next_s;
  logic [AW:0]   n_r, n_start_s;
  logic [3:0]    wait_cnt_r;
  logic          idle_s, waddr_ok_s, cmp_fail_s, is_last_s;
  logic [AW:0]   pass_next_s, fail_next_s;
  logic [AW-1:0] ff_idx_next_s;
  logic          ff_valid_next_s;

  // Out-of-range write addresses can only occur when DEPTH is not a power of two.
  if ((1 << AW) == DEPTH) begin : g_pow2
    assign waddr_ok_s = 1'b1;
  end else begin : g_npow2
    assign waddr_ok_s = ({1'b0, vec_waddr} < DEPTH_W);
  end

  assign idle_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

  // Vector RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && vec_we && idle_s && waddr_ok_s) begin
      stim_mem_r[vec_waddr] <= vec_stim;
      exp_mem_r[vec_waddr]  <= vec_exp;
      mask_mem_r[vec_waddr] <= vec_mask;
    end
  end

  // Next-state, next-index and scoreboard update logic.
  always_comb begin
    state_next_s    = state_r;
    idx_next_s      = idx_r;
    pass_next_s     = pass_count;
    fail_next_s     = fail_count;
    ff_idx_next_s   = first_fail_idx;
    ff_valid_next_s = first_fail_valid;
    n_start_s       = (num_vecs > DEPTH_W) ? DEPTH_W : num_vecs;
    cmp_fail_s      = |((dut_resp ^ exp_mem_r[idx_r]) & mask_mem_r[idx_r]);
    is_last_s       = (({1'b0, idx_r} + CNT_ONE) == n_r);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_next_s      = IDX_ZERO;
          pass_next_s     = CNT_ZERO;
          fail_next_s     = CNT_ZERO;
          ff_idx_next_s   = IDX_ZERO;
          ff_valid_next_s = 1'b0;
          if (n_start_s == CNT_ZERO) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_DRIVE;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DRIVE: begin
        if (LAT > 1) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_CMP;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_next_s = ST_CMP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_CMP: begin
        if (cmp_fail_s) begin
          fail_next_s = fail_count + CNT_ONE;
          if (!first_fail_valid) begin
            ff_idx_next_s   = idx_r;
            ff_valid_next_s = 1'b1;
          end else begin
            ff_idx_next_s   = first_fail_idx;
          end
        end else begin
          pass_next_s = pass_count + CNT_ONE;
        end
        if (is_last_s || (cmp_fail_s && (STOP_ON_FAIL != 0))) begin
          state_next_s = ST_DONE;
        end else begin
          idx_next_s   = idx_r + IDX_ONE;
          state_next_s = ST_DRIVE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, run bookkeeping and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      dut_stim         <= {WIDTH{1'b0}};
      dut_valid        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      all_pass         <= 1'b0;
      pass_count       <= CNT_ZERO;
      fail_count       <= CNT_ZERO;
      first_fail_idx   <= IDX_ZERO;
      first_fail_valid <= 1'b0;
      idx_r            <= IDX_ZERO;
      n_r              <= CNT_ZERO;
      wait_cnt_r       <= 4'd0;
    end else begin
      dut_valid        <= (state_next_s == ST_DRIVE);
      busy             <= (state_next_s == ST_DRIVE) || (state_next_s == ST_WAIT) ||
                          (state_next_s == ST_CMP);
      done             <= (state_next_s == ST_DONE);
      all_pass         <= (state_next_s == ST_DONE) && (fail_next_s == CNT_ZERO);
      pass_count       <= pass_next_s;
      fail_count       <= fail_next_s;
      first_fail_idx   <= ff_idx_next_s;
      first_fail_valid <= ff_valid_next_s;
      idx_r            <= idx_next_s;
      if (state_next_s == ST_DRIVE) begin
        dut_stim <= stim_mem_r[idx_next_s];
      end
      if (idle_s && start) begin
        n_r <= n_start_s;
      end
      if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= 4'd0;
      end
    end
  end

endmodule
